psram_responder: RTL and testbench

Synthesizable responder for the external cellular-RAM (PSRAM) pin interface driven by the RAM controller `state_machine`. It latches addresses and commands from the controller, models access latency with `wait_z`, and serves reads and byte-masked writes from a small internal word array. It also captures configuration-register writes, so the controller can be exercised in simulation and on-chip loopback without the physical device.

---
 rtl/psram_responder.sv | 134 +++++++++++++
 tb/tb_psram_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_responder.sv
// psram_responder: PSRAM pin responder with latency model, byte-masked word array and config register.
// Read/write data phase LATENCY edges after latch, no backpressure (wait_z only); checker via PSRAM_RESP_CHECK_EN.
module psram_responder #(
   parameter int          MEM_AW  = 8,
   parameter int          LATENCY = 3,
   parameter logic [15:0] CFG_RST = 16'h9D1F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [25:0] addr,
   inout  wire  [15:0] data_ram,
   input  logic        mt_ce_n,
   input  logic        adv_z,
   input  logic        oe_n,
   input  logic        we_n,
   input  logic        mt_lb_n,
   input  logic        mt_ub_n,
   input  logic        mt_cre,
   output logic        wait_z,
   output logic [15:0] cfg_reg,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DATA, CFG} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [MEM_AW-1:0] r_addr;
   logic              r_wait;
   logic [15:0]       r_cfg;
   logic [15:0]       r_mem [2**MEM_AW];

   logic              w_latch;
   logic              w_drive;
   logic [15:0]       w_rd_word;
   logic [15:0]       w_rd_dat;
   logic              w_unused;

   assign w_latch   = (r_state == IDLE) && !mt_ce_n && !adv_z;
   assign w_rd_word = r_mem[r_addr];
   assign w_rd_dat  = {mt_ub_n ? 8'h00 : w_rd_word[15:8], mt_lb_n ? 8'h00 : w_rd_word[7:0]};
   // Bus turn-on/turn-off follows oe_n/mt_ce_n combinationally once the data phase is reached.
   assign w_drive   = (r_state == RD_DATA) && !oe_n && !mt_ce_n;
   assign data_ram  = w_drive ? w_rd_dat : 16'hzzzz;
   assign wait_z    = r_wait;
   assign cfg_reg   = r_cfg;
   assign w_unused  = ^addr[25:16];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wait  <= 1'b0;
         r_cfg   <= CFG_RST;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_latch) begin
                  r_addr <= addr[MEM_AW-1:0];
                  r_cnt  <= LAT_M1;
                  r_wait <= 1'b1;
                  if (mt_cre) begin
                     r_state <= CFG;
                     r_cfg   <= addr[15:0];
                  end else if (!we_n) begin
                     r_state <= WR_WAIT;
                  end else begin
                     r_state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT, WR_WAIT: begin
               if (mt_ce_n) begin
                  r_state <= IDLE;
                  r_wait  <= 1'b0;
               end else if (r_cnt == 4'd0) begin
                  r_wait <= 1'b0;
                  if (r_state == RD_WAIT) r_state <= RD_DATA;
                  else                    r_state <= WR_DATA;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RD_DATA, WR_DATA: begin
               if (mt_ce_n) r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_wait  <= 1'b0;
            end
         endcase
      end
   end

   // Array has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (r_state == WR_DATA && !mt_ce_n && !we_n) begin
         if (!mt_lb_n) r_mem[r_addr][7:0]  <= data_ram[7:0];
         if (!mt_ub_n) r_mem[r_addr][15:8] <= data_ram[15:8];
      end
   end

`ifdef PSRAM_RESP_CHECK_EN
   logic       r_err;
   logic       r_we_d;
   logic [3:0] w_viol;

   assign w_viol[0] = !oe_n && !we_n && !mt_ce_n;
   assign w_viol[1] = !adv_z && (r_state != IDLE);
   assign w_viol[2] = w_latch && (addr[25:MEM_AW] != '0);
   assign w_viol[3] = ((r_state == RD_WAIT) || (r_state == WR_WAIT)) && (we_n != r_we_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err  <= 1'b0;
         r_we_d <= 1'b1;
      end else begin
         r_we_d <= we_n;
         if (|w_viol) begin
            r_err <= 1'b1;
            $display("%0t psram_responder: protocol violation code %b", $time, w_viol);
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: table vectors, directed corner sequences and randomized traffic vs an array model.
// Undriven bus reads as 16'hFFFF through a pulled-up net.
module tb_psram_responder;
   localparam int LAT = 3;
`ifdef PSRAM_RESP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [25:0] addr;
   logic        mt_ce_n, adv_z, oe_n, we_n, mt_lb_n, mt_ub_n, mt_cre;
   logic        wait_z, err;
   logic [15:0] cfg_reg;
   tri1  [15:0] data_ram;
   logic [15:0] tb_dout;
   logic        tb_drv;

   assign data_ram = tb_drv ? tb_dout : 16'hzzzz;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] mref [256];
   logic        err_exp = 1'b0;
   logic [15:0] d;
   int          nw;

   typedef struct {
      logic [25:0] a;
      logic [15:0] wd;
      logic        wlb_n, wub_n, rlb_n, rub_n;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [6];

   psram_responder dut (
      .clk(clk), .rst(rst), .addr(addr), .data_ram(data_ram),
      .mt_ce_n(mt_ce_n), .adv_z(adv_z), .oe_n(oe_n), .we_n(we_n),
      .mt_lb_n(mt_lb_n), .mt_ub_n(mt_ub_n), .mt_cre(mt_cre),
      .wait_z(wait_z), .cfg_reg(cfg_reg), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw_d,
                                         input logic lbn, input logic ubn);
      return {ubn ? old[15:8] : nw_d[15:8], lbn ? old[7:0] : nw_d[7:0]};
   endfunction

   function automatic logic [15:0] rd_model(input logic [15:0] w, input logic lbn, input logic ubn);
      return {ubn ? 8'h00 : w[15:8], lbn ? 8'h00 : w[7:0]};
   endfunction

   task automatic do_write(input logic [25:0] a, input logic [15:0] wd, input logic lbn, input logic ubn);
      int n;
      @(negedge clk);
      addr = a; mt_ce_n = 0; adv_z = 0; we_n = 0; oe_n = 1; mt_cre = 0;
      mt_lb_n = lbn; mt_ub_n = ubn; tb_dout = wd; tb_drv = 1;
      @(negedge clk);
      adv_z = 1; n = 0;
      while (wait_z === 1'b1 && n < 20) begin n++; @(negedge clk); end
      check("wr_wait_cycles", n, LAT);
      @(negedge clk);
      mt_ce_n = 1; we_n = 1; tb_drv = 0;
      @(negedge clk);
      mref[a[7:0]] = merge(mref[a[7:0]], wd, lbn, ubn);
      if (CHK && a[25:8] != '0) err_exp = 1'b1;
      check("wr_err", err, err_exp);
   endtask

   task automatic do_read(input logic [25:0] a, input logic lbn, input logic ubn,
                          output logic [15:0] rd, output int n);
      @(negedge clk);
      addr = a; mt_ce_n = 0; adv_z = 0; we_n = 1; oe_n = 0; mt_cre = 0;
      mt_lb_n = lbn; mt_ub_n = ubn; tb_drv = 0;
      @(negedge clk);
      adv_z = 1; n = 0;
      check("rd_wait_bus_z", data_ram, 16'hFFFF);
      while (wait_z === 1'b1 && n < 20) begin n++; @(negedge clk); end
      check("rd_wait_cycles", n, LAT);
      rd = data_ram;
      mt_ce_n = 1; oe_n = 1;
      #1 check("rd_bus_off", data_ram, 16'hFFFF);
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{26'd0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001};
      tbl[1] = '{26'd5, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 16'hABCD};
      tbl[2] = '{26'd5, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAB34};
      tbl[3] = '{26'd6, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h005A};
      tbl[4] = '{26'd6, 16'hC3C3, 1'b1, 1'b0, 1'b1, 1'b0, 16'hC300};
      tbl[5] = '{26'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

      rst = 1; addr = '0; mt_ce_n = 1; adv_z = 1; oe_n = 1; we_n = 1;
      mt_lb_n = 0; mt_ub_n = 0; mt_cre = 0; tb_dout = '0; tb_drv = 0;
      @(negedge clk);
      check("rst_wait_z", wait_z, 1'b0);
      check("rst_cfg", cfg_reg, 16'h9D1F);
      check("rst_err", err, 1'b0);
      check("rst_bus_z", data_ram, 16'hFFFF);
      rst = 0;

      for (int i = 0; i < 6; i++) begin
         do_write(tbl[i].a, tbl[i].wd, tbl[i].wlb_n, tbl[i].wub_n);
         do_read(tbl[i].a, tbl[i].rlb_n, tbl[i].rub_n, d, nw);
         check($sformatf("tbl_rd_%0d", i), d, tbl[i].exp);
      end

      // Output enable gates the bus combinationally during the read data phase.
      @(negedge clk);
      addr = 26'd5; mt_ce_n = 0; adv_z = 0; we_n = 1; oe_n = 0; mt_lb_n = 0; mt_ub_n = 0;
      @(negedge clk);
      adv_z = 1;
      repeat (LAT) @(negedge clk);
      check("oe_rd_data", data_ram, 16'hAB34);
      oe_n = 1;
      #1 check("oe_off", data_ram, 16'hFFFF);
      oe_n = 0;
      #1 check("oe_on", data_ram, 16'hAB34);
      mt_lb_n = 1;
      #1 check("oe_lb_mask", data_ram, 16'hAB00);
      mt_ce_n = 1; oe_n = 1; mt_lb_n = 0;
      @(negedge clk);

      // Config register write leaves the array alone.
      do_write(26'h23, 16'h1357, 0, 0);
      @(negedge clk);
      addr = 26'h0000_8123; mt_ce_n = 0; adv_z = 0; mt_cre = 1; we_n = 1; oe_n = 1;
      @(negedge clk);
      adv_z = 1; mt_ce_n = 1; mt_cre = 0;
      if (CHK) err_exp = 1'b1;
      check("cfg_value", cfg_reg, 16'h8123);
      check("cfg_wait_hi", wait_z, 1'b1);
      @(negedge clk);
      check("cfg_wait_lo", wait_z, 1'b0);
      do_read(26'h23, 0, 0, d, nw);
      check("cfg_array_kept", d, 16'h1357);

      // Abort one cycle into a write: no write, no bus drive.
      @(negedge clk);
      addr = 26'd7; mt_ce_n = 0; adv_z = 0; we_n = 0; oe_n = 1; mt_lb_n = 0; mt_ub_n = 0;
      @(negedge clk);
      check("abort_wait_hi", wait_z, 1'b1);
      adv_z = 1; mt_ce_n = 1; we_n = 1;
      @(negedge clk);
      check("abort_wait_lo", wait_z, 1'b0);
      check("abort_bus_z", data_ram, 16'hFFFF);
      repeat (4) @(negedge clk);
      check("abort_idle", wait_z, 1'b0);
      do_read(26'd7, 0, 0, d, nw);
      check("abort_rd", d, 16'h0000);

      // Randomized traffic against the array model.
      for (int i = 0; i < 32; i++) do_write(26'(i), 16'($urandom_range(16'hFFFE)), 0, 0);
      for (int i = 0; i < 80; i++) begin
         logic [25:0] ra;
         logic        lbn, ubn;
         ra  = 26'($urandom_range(31));
         lbn = 1'($urandom_range(1));
         ubn = 1'($urandom_range(1));
         if ($urandom_range(1) == 1) begin
            do_write(ra, 16'($urandom_range(16'hFFFE)), lbn, ubn);
         end else begin
            do_read(ra, lbn, ubn, d, nw);
            check("rand_rd", d, rd_model(mref[ra[7:0]], lbn, ubn));
         end
      end

      // Upper address bits alias; checker build flags them.
      do_write(26'h103, 16'h7777, 0, 0);
      do_read(26'd3, 0, 0, d, nw);
      check("alias_rd", d, 16'h7777);
      repeat (3) @(negedge clk);
      check("err_sticky", err, err_exp);

      // Reset in the middle of a read latency window.
      @(negedge clk);
      addr = 26'd3; mt_ce_n = 0; adv_z = 0; we_n = 1; oe_n = 0;
      @(negedge clk);
      adv_z = 1;
      check("mid_wait_hi", wait_z, 1'b1);
      rst = 1;
      #1;
      check("mid_rst_wait", wait_z, 1'b0);
      check("mid_rst_cfg", cfg_reg, 16'h9D1F);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_bus", data_ram, 16'hFFFF);
      @(negedge clk);
      rst = 0; mt_ce_n = 1; oe_n = 1; err_exp = 1'b0;
      @(negedge clk);
      check("post_rst_idle", wait_z, 1'b0);
      do_read(26'd3, 0, 0, d, nw);
      check("array_survives_rst", d, 16'h7777);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
